// File: rtl/gobou_pkg.sv
// gobou_pkg: shared constants and types for the gobou fully-connected datapath.
// The pipeline depths describe the MAC -> bias -> ReLU stages that sit
// between the sequencer's operand beats and the result write-back.
package gobou_pkg;

   localparam int D_MAC  = 2;
   localparam int D_BIAS = 1;
   localparam int D_RELU = 1;
   localparam int D_PIPE = D_MAC + D_BIAS + D_RELU;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } sched_state_t;

endpackage

// File: rtl/ctrl_fc_delay.sv
// ctrl_fc_delay: fixed-depth 1-bit shift register that tracks end-of-neuron
// markers through the datapath pipeline. q_o is the marker leaving the last
// stage; pending_o reports markers that are still in flight behind it, so
// the sequencer can tell one cycle ahead that the pipeline will be empty.
module ctrl_fc_delay #(
   parameter int DEPTH = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o,
   output logic pending_o
);

   localparam logic [DEPTH-1:0] BEHIND_MASK = {DEPTH{1'b1}} >> 1;

   logic [DEPTH-1:0] shift_q;

   // Shift markers one stage per clock; an asynchronous clear drops anything in flight
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shift_q <= '0;
      end else begin
         shift_q <= (shift_q << 1) | DEPTH'(d_i);
      end
   end

   assign q_o       = shift_q[DEPTH-1];
   assign pending_o = |(shift_q & BEHIND_MASK);

endmodule

// File: rtl/ctrl_fc_sched.sv
// ctrl_fc_sched: layer sequencer for the gobou fully-connected datapath.
// Accepts one layer command, walks every output neuron over every input
// element, drives operand addresses plus the start/valid/stop stream, and
// issues result writes as each neuron's sum leaves the ReLU stage.
module ctrl_fc_sched
   import gobou_pkg::*;
#(
   parameter int IN_W    = 10,
   parameter int OUT_W   = 10,
   parameter int WADDR_W = 16
) (
   input  logic               clk,
   input  logic               xrst,
   input  logic               req,
   input  logic [IN_W-1:0]    in_size,
   input  logic [OUT_W-1:0]   out_size,
   input  logic               relu_en,
   output logic               busy,
   output logic               ack,
   output logic [IN_W-1:0]    in_addr,
   output logic [WADDR_W-1:0] w_addr,
   output logic               acc_clear,
   output logic               ctrl_start,
   output logic               ctrl_valid,
   output logic               ctrl_stop,
   output logic               relu_bypass,
   output logic [OUT_W-1:0]   out_addr,
   output logic               out_we
);

   sched_state_t state_q, state_d;

   logic [IN_W-1:0]    inSize_q, inSize_d;
   logic [OUT_W-1:0]   outSize_q, outSize_d;
   logic               reluBypass_q, reluBypass_d;
   logic [IN_W-1:0]    inCnt_q, inCnt_d;
   logic [OUT_W-1:0]   outCnt_q, outCnt_d;
   logic [WADDR_W-1:0] wCnt_q, wCnt_d;
   logic [OUT_W-1:0]   wrCnt_q, wrCnt_d;

   logic               accept;
   logic               emptyCmd;
   logic               lastIn;
   logic               lastOut;
   logic               endOfNeuron;
   logic               resultWe;
   logic               pipePending;
   logic [OUT_W-1:0]   wrCntNext;
   logic               drainDone;

   assign accept      = (state_q == IDLE) && req;
   assign emptyCmd    = (in_size == '0) || (out_size == '0);
   assign lastIn      = (inCnt_q == inSize_q - IN_W'(1));
   assign lastOut     = (outCnt_q == outSize_q - OUT_W'(1));
   assign endOfNeuron = (state_q == ACC) && lastIn;

   // The drain check looks one cycle ahead: the write leaving the pipeline
   // this cycle is already counted, so ack lands right after the last write.
   assign wrCntNext   = wrCnt_q + OUT_W'(resultWe);
   assign drainDone   = !pipePending && (wrCntNext == outSize_q);

   ctrl_fc_delay #(
      .DEPTH(D_PIPE)
   ) uDelay (
      .clk_i     (clk),
      .rst_i     (xrst),
      .d_i       (endOfNeuron),
      .q_o       (resultWe),
      .pending_o (pipePending)
   );

   // State register
   always_ff @(posedge clk or posedge xrst) begin
      if (xrst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: an empty command skips straight to completion
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               state_d = emptyCmd ? DONE : ACC;
            end
         end
         ACC: begin
            if (lastIn && lastOut) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (drainDone) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Command latch and counter next-state; neurons run back-to-back with no bubble
   always_comb begin
      inSize_d     = inSize_q;
      outSize_d    = outSize_q;
      reluBypass_d = reluBypass_q;
      inCnt_d      = inCnt_q;
      outCnt_d     = outCnt_q;
      wCnt_d       = wCnt_q;
      wrCnt_d      = wrCntNext;
      if (accept) begin
         inSize_d     = in_size;
         outSize_d    = out_size;
         reluBypass_d = ~relu_en;
         inCnt_d      = '0;
         outCnt_d     = '0;
         wCnt_d       = '0;
         wrCnt_d      = '0;
      end else if (state_q == ACC) begin
         wCnt_d = wCnt_q + WADDR_W'(1);
         if (lastIn) begin
            inCnt_d  = '0;
            outCnt_d = outCnt_q + OUT_W'(1);
         end else begin
            inCnt_d = inCnt_q + IN_W'(1);
         end
      end
   end

   // Command and counter registers; reset abandons any partially written layer
   always_ff @(posedge clk or posedge xrst) begin
      if (xrst) begin
         inSize_q     <= '0;
         outSize_q    <= '0;
         reluBypass_q <= 1'b0;
         inCnt_q      <= '0;
         outCnt_q     <= '0;
         wCnt_q       <= '0;
         wrCnt_q      <= '0;
      end else begin
         inSize_q     <= inSize_d;
         outSize_q    <= outSize_d;
         reluBypass_q <= reluBypass_d;
         inCnt_q      <= inCnt_d;
         outCnt_q     <= outCnt_d;
         wCnt_q       <= wCnt_d;
         wrCnt_q      <= wrCnt_d;
      end
   end

   // Output decode: operand addresses and beat flags are only live while accumulating
   always_comb begin
      busy        = (state_q != IDLE);
      ack         = (state_q == DONE);
      ctrl_valid  = 1'b0;
      in_addr     = '0;
      w_addr      = '0;
      acc_clear   = 1'b0;
      ctrl_start  = 1'b0;
      ctrl_stop   = 1'b0;
      relu_bypass = reluBypass_q;
      out_addr    = wrCnt_q;
      out_we      = resultWe;
      if (state_q == ACC) begin
         ctrl_valid = 1'b1;
         in_addr    = inCnt_q;
         w_addr     = wCnt_q;
         acc_clear  = (inCnt_q == '0);
         ctrl_start = (inCnt_q == '0) && (outCnt_q == '0);
         ctrl_stop  = lastIn && lastOut;
      end
   end

endmodule

// File: tb/tb_ctrl_fc_sched.sv
// tb_ctrl_fc_sched: directed scenarios for the fully-connected layer sequencer.
// Cycle 0 is the cycle in which req is high and accepted; cycle n is the
// n-th cycle after that accepting edge. Outputs are sampled on the falling edge.
module tb_ctrl_fc_sched;
   import gobou_pkg::*;

   logic        clk = 1'b0;
   logic        xrst;
   logic        req;
   logic [9:0]  inSize;
   logic [9:0]  outSize;
   logic        reluEn;

   logic        busy, ack, ctrlValid, accClear, ctrlStart, ctrlStop, reluBypass, outWe;
   logic [9:0]  inAddr, outAddr;
   logic [15:0] wAddr;

   logic        busyN, ackN, ctrlValidN, accClearN, ctrlStartN, ctrlStopN, reluBypassN, outWeN;
   logic [9:0]  inAddrN, outAddrN;
   logic [3:0]  wAddrN;

   int checks = 0;
   int errors = 0;

   int          nBeats, nWe, nAck, ackCyc, busyFall;
   logic        bypassAt1, busyAt1;
   int          beatCyc   [64];
   logic [9:0]  beatIn    [64];
   logic [15:0] beatW     [64];
   logic        beatClr   [64];
   logic        beatStart [64];
   logic        beatStop  [64];
   int          weCyc     [16];
   logic [9:0]  weAddr    [16];

   always #5 clk = ~clk;

   ctrl_fc_sched #(.IN_W(10), .OUT_W(10), .WADDR_W(16)) dut (
      .clk(clk), .xrst(xrst), .req(req), .in_size(inSize), .out_size(outSize),
      .relu_en(reluEn), .busy(busy), .ack(ack), .in_addr(inAddr), .w_addr(wAddr),
      .acc_clear(accClear), .ctrl_start(ctrlStart), .ctrl_valid(ctrlValid),
      .ctrl_stop(ctrlStop), .relu_bypass(reluBypass), .out_addr(outAddr), .out_we(outWe)
   );

   ctrl_fc_sched #(.IN_W(10), .OUT_W(10), .WADDR_W(4)) dutNarrow (
      .clk(clk), .xrst(xrst), .req(req), .in_size(inSize), .out_size(outSize),
      .relu_en(reluEn), .busy(busyN), .ack(ackN), .in_addr(inAddrN), .w_addr(wAddrN),
      .acc_clear(accClearN), .ctrl_start(ctrlStartN), .ctrl_valid(ctrlValidN),
      .ctrl_stop(ctrlStopN), .relu_bypass(reluBypassN), .out_addr(outAddrN), .out_we(outWeN)
   );

   // Drives one layer command starting in the current cycle (caller sits just after a
   // falling edge) and records every beat, write and ack until busy drops.
   // Optional extra req pulses (with different sizes) are applied at cycles pulseA/pulseB.
   task automatic captureLayer(input int inSz, input int outSz, input logic relu,
                               input bit narrow, input int pulseA, input int pulseB);
      logic sBusy, sAck, sValid, sClr, sStart, sStop, sWe, sByp;
      logic [9:0] sIn, sOut;
      logic [15:0] sW;
      nBeats = 0; nWe = 0; nAck = 0; ackCyc = -1; busyFall = -1;
      bypassAt1 = 1'bx; busyAt1 = 1'bx;
      inSize  = 10'(inSz);
      outSize = 10'(outSz);
      reluEn  = relu;
      req     = 1'b1;
      for (int cyc = 1; cyc <= 300; cyc++) begin
         @(negedge clk);
         req    = 1'b0;
         sBusy  = narrow ? busyN       : busy;
         sAck   = narrow ? ackN        : ack;
         sValid = narrow ? ctrlValidN  : ctrlValid;
         sClr   = narrow ? accClearN   : accClear;
         sStart = narrow ? ctrlStartN  : ctrlStart;
         sStop  = narrow ? ctrlStopN   : ctrlStop;
         sWe    = narrow ? outWeN      : outWe;
         sByp   = narrow ? reluBypassN : reluBypass;
         sIn    = narrow ? inAddrN     : inAddr;
         sOut   = narrow ? outAddrN    : outAddr;
         sW     = narrow ? 16'(wAddrN) : wAddr;
         if (cyc == 1) begin
            bypassAt1 = sByp;
            busyAt1   = sBusy;
         end
         if (sValid && nBeats < 64) begin
            beatCyc[nBeats]   = cyc;
            beatIn[nBeats]    = sIn;
            beatW[nBeats]     = sW;
            beatClr[nBeats]   = sClr;
            beatStart[nBeats] = sStart;
            beatStop[nBeats]  = sStop;
            nBeats++;
         end
         if (sWe && nWe < 16) begin
            weCyc[nWe]  = cyc;
            weAddr[nWe] = sOut;
            nWe++;
         end
         if (sAck) begin
            nAck++;
            if (ackCyc < 0) ackCyc = cyc;
         end
         if (!sBusy) begin
            busyFall = cyc;
            break;
         end
         if (cyc == pulseA || cyc == pulseB) begin
            req     = 1'b1;
            inSize  = 10'd2;
            outSize = 10'd1;
         end
      end
   endtask

   // Reset state of both instances, then release
   task automatic test_reset();
      xrst = 1'b1; req = 1'b0; inSize = '0; outSize = '0; reluEn = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, ack, ctrlValid, accClear, ctrlStart, ctrlStop, reluBypass, outWe} !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %b expected 00000000",
                  {busy, ack, ctrlValid, accClear, ctrlStart, ctrlStop, reluBypass, outWe});
      end
      checks++;
      if ({inAddr, outAddr, wAddr} !== 36'h0) begin
         errors++;
         $display("[TB] FAIL reset_addr: got in=%0d out=%0d w=%0d expected 0 0 0", inAddr, outAddr, wAddr);
      end
      checks++;
      if ({busyN, ackN, outWeN, wAddrN} !== 7'h00) begin
         errors++;
         $display("[TB] FAIL reset_narrow: got %b expected 0000000", {busyN, ackN, outWeN, wAddrN});
      end
      xrst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_after_reset: busy got %b expected 0", busy);
      end
   endtask

   // 4 inputs x 3 neurons with ReLU enabled
   task automatic test_basic();
      captureLayer(4, 3, 1'b1, 1'b0, 0, 0);
      checks++;
      if (nBeats !== 12) begin
         errors++;
         $display("[TB] FAIL basic_beats: got %0d expected 12", nBeats);
      end
      for (int b = 0; b < 12 && b < nBeats; b++) begin
         checks++;
         if (beatCyc[b] !== b + 1 || beatIn[b] !== 10'(b % 4) || beatW[b] !== 16'(b) ||
             beatClr[b] !== (b % 4 == 0) || beatStart[b] !== (b == 0) || beatStop[b] !== (b == 11)) begin
            errors++;
            $display("[TB] FAIL basic_beat%0d: got cyc=%0d in=%0d w=%0d clr=%b st=%b sp=%b expected cyc=%0d in=%0d w=%0d clr=%b st=%b sp=%b",
                     b, beatCyc[b], beatIn[b], beatW[b], beatClr[b], beatStart[b], beatStop[b],
                     b + 1, b % 4, b, (b % 4 == 0), (b == 0), (b == 11));
         end
      end
      checks++;
      if (nWe !== 3) begin
         errors++;
         $display("[TB] FAIL basic_writes: got %0d expected 3", nWe);
      end
      for (int k = 0; k < 3 && k < nWe; k++) begin
         checks++;
         if (weCyc[k] !== (k + 1) * 4 + D_PIPE || weAddr[k] !== 10'(k)) begin
            errors++;
            $display("[TB] FAIL basic_we%0d: got cyc=%0d addr=%0d expected cyc=%0d addr=%0d",
                     k, weCyc[k], weAddr[k], (k + 1) * 4 + D_PIPE, k);
         end
      end
      checks++;
      if (ackCyc !== 13 + D_PIPE || nAck !== 1) begin
         errors++;
         $display("[TB] FAIL basic_ack: got cyc=%0d count=%0d expected cyc=%0d count=1", ackCyc, nAck, 13 + D_PIPE);
      end
      checks++;
      if (busyFall !== 14 + D_PIPE || busyAt1 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL basic_busy: got fall=%0d at1=%b expected fall=%0d at1=1", busyFall, busyAt1, 14 + D_PIPE);
      end
      checks++;
      if (bypassAt1 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_bypass: got %b expected 0", bypassAt1);
      end
   endtask

   // Empty command completes immediately with no beats or writes
   task automatic test_empty();
      captureLayer(0, 5, 1'b1, 1'b0, 0, 0);
      checks++;
      if (ackCyc !== 1 || nAck !== 1 || busyFall !== 2) begin
         errors++;
         $display("[TB] FAIL empty_ack: got ack=%0d count=%0d fall=%0d expected ack=1 count=1 fall=2", ackCyc, nAck, busyFall);
      end
      checks++;
      if (nBeats !== 0 || nWe !== 0) begin
         errors++;
         $display("[TB] FAIL empty_activity: got beats=%0d writes=%0d expected 0 0", nBeats, nWe);
      end
   endtask

   // Single-beat layer: start, stop and clear coincide; bypass follows relu_en=0
   task automatic test_single();
      captureLayer(1, 1, 1'b0, 1'b0, 0, 0);
      checks++;
      if (nBeats !== 1 || beatCyc[0] !== 1 || beatClr[0] !== 1'b1 || beatStart[0] !== 1'b1 ||
          beatStop[0] !== 1'b1 || beatW[0] !== 16'd0 || beatIn[0] !== 10'd0) begin
         errors++;
         $display("[TB] FAIL single_beat: got n=%0d cyc=%0d clr=%b st=%b sp=%b w=%0d in=%0d expected n=1 cyc=1 clr=1 st=1 sp=1 w=0 in=0",
                  nBeats, beatCyc[0], beatClr[0], beatStart[0], beatStop[0], beatW[0], beatIn[0]);
      end
      checks++;
      if (nWe !== 1 || weCyc[0] !== 1 + D_PIPE || weAddr[0] !== 10'd0) begin
         errors++;
         $display("[TB] FAIL single_we: got n=%0d cyc=%0d addr=%0d expected n=1 cyc=%0d addr=0", nWe, weCyc[0], weAddr[0], 1 + D_PIPE);
      end
      checks++;
      if (ackCyc !== 2 + D_PIPE) begin
         errors++;
         $display("[TB] FAIL single_ack: got %0d expected %0d", ackCyc, 2 + D_PIPE);
      end
      checks++;
      if (bypassAt1 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL single_bypass: got %b expected 1", bypassAt1);
      end
   endtask

   // A new req in the cycle busy drops is accepted immediately
   task automatic test_back_to_back();
      captureLayer(1, 2, 1'b1, 1'b0, 0, 0);
      checks++;
      if (nBeats !== 2 || beatStart[0] !== 1'b1 || beatStop[0] !== 1'b0 || beatStop[1] !== 1'b1 ||
          beatClr[1] !== 1'b1 || ackCyc !== 3 + D_PIPE) begin
         errors++;
         $display("[TB] FAIL b2b_first: got n=%0d st0=%b sp0=%b sp1=%b clr1=%b ack=%0d expected n=2 st0=1 sp0=0 sp1=1 clr1=1 ack=%0d",
                  nBeats, beatStart[0], beatStop[0], beatStop[1], beatClr[1], ackCyc, 3 + D_PIPE);
      end
      checks++;
      if (nWe !== 2 || weCyc[0] !== 1 + D_PIPE || weCyc[1] !== 2 + D_PIPE || weAddr[1] !== 10'd1) begin
         errors++;
         $display("[TB] FAIL b2b_writes: got n=%0d c0=%0d c1=%0d a1=%0d expected n=2 c0=%0d c1=%0d a1=1",
                  nWe, weCyc[0], weCyc[1], weAddr[1], 1 + D_PIPE, 2 + D_PIPE);
      end
      captureLayer(2, 1, 1'b1, 1'b0, 0, 0);
      checks++;
      if (nBeats !== 2 || beatCyc[0] !== 1 || beatIn[1] !== 10'd1 || beatW[1] !== 16'd1 ||
          beatClr[1] !== 1'b0 || ackCyc !== 3 + D_PIPE) begin
         errors++;
         $display("[TB] FAIL b2b_second: got n=%0d cyc0=%0d in1=%0d w1=%0d clr1=%b ack=%0d expected n=2 cyc0=1 in1=1 w1=1 clr1=0 ack=%0d",
                  nBeats, beatCyc[0], beatIn[1], beatW[1], beatClr[1], ackCyc, 3 + D_PIPE);
      end
   endtask

   // req pulses (with other sizes) during a running layer are ignored
   task automatic test_req_ignored();
      captureLayer(4, 3, 1'b1, 1'b0, 3, 6);
      checks++;
      if (nBeats !== 12) begin
         errors++;
         $display("[TB] FAIL ignore_beats: got %0d expected 12", nBeats);
      end
      for (int b = 0; b < 12 && b < nBeats; b++) begin
         checks++;
         if (beatCyc[b] !== b + 1 || beatIn[b] !== 10'(b % 4) || beatW[b] !== 16'(b) ||
             beatStop[b] !== (b == 11)) begin
            errors++;
            $display("[TB] FAIL ignore_beat%0d: got cyc=%0d in=%0d w=%0d sp=%b expected cyc=%0d in=%0d w=%0d sp=%b",
                     b, beatCyc[b], beatIn[b], beatW[b], beatStop[b], b + 1, b % 4, b, (b == 11));
         end
      end
      checks++;
      if (nWe !== 3 || ackCyc !== 13 + D_PIPE || nAck !== 1) begin
         errors++;
         $display("[TB] FAIL ignore_done: got writes=%0d ack=%0d count=%0d expected 3 %0d 1", nWe, ackCyc, nAck, 13 + D_PIPE);
      end
   endtask

   // Asynchronous reset at cycle 7 abandons the layer; a fresh req restarts cleanly
   task automatic test_mid_reset();
      int lateAck, lateWe, lateBusy;
      lateAck = 0; lateWe = 0; lateBusy = 0;
      inSize = 10'd4; outSize = 10'd3; reluEn = 1'b0; req = 1'b1;
      for (int cyc = 1; cyc <= 7; cyc++) begin
         @(negedge clk);
         req = 1'b0;
         if (cyc == 1) begin
            checks++;
            if (reluBypass !== 1'b1) begin
               errors++;
               $display("[TB] FAIL rst_bypass_before: got %b expected 1", reluBypass);
            end
         end
      end
      checks++;
      if (ctrlValid !== 1'b1 || wAddr !== 16'd6) begin
         errors++;
         $display("[TB] FAIL rst_running: got valid=%b w=%0d expected valid=1 w=6", ctrlValid, wAddr);
      end
      xrst = 1'b1;
      #1;
      checks++;
      if ({busy, ack, ctrlValid, accClear, ctrlStart, ctrlStop, reluBypass, outWe} !== 8'h00) begin
         errors++;
         $display("[TB] FAIL rst_async_flags: got %b expected 00000000",
                  {busy, ack, ctrlValid, accClear, ctrlStart, ctrlStop, reluBypass, outWe});
      end
      checks++;
      if ({inAddr, outAddr, wAddr} !== 36'h0) begin
         errors++;
         $display("[TB] FAIL rst_async_addr: got in=%0d out=%0d w=%0d expected 0 0 0", inAddr, outAddr, wAddr);
      end
      @(negedge clk);
      xrst = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (ack) lateAck++;
         if (outWe) lateWe++;
         if (busy) lateBusy++;
      end
      checks++;
      if (lateAck !== 0 || lateWe !== 0 || lateBusy !== 0) begin
         errors++;
         $display("[TB] FAIL rst_abandoned: got ack=%0d we=%0d busy=%0d expected 0 0 0", lateAck, lateWe, lateBusy);
      end
      captureLayer(4, 3, 1'b1, 1'b0, 0, 0);
      checks++;
      if (nBeats !== 12 || beatCyc[0] !== 1 || beatW[0] !== 16'd0 || beatW[11] !== 16'd11 ||
          nWe !== 3 || weAddr[0] !== 10'd0 || ackCyc !== 13 + D_PIPE) begin
         errors++;
         $display("[TB] FAIL rst_restart: got n=%0d c0=%0d w0=%0d w11=%0d we=%0d a0=%0d ack=%0d expected 12 1 0 11 3 0 %0d",
                  nBeats, beatCyc[0], beatW[0], beatW[11], nWe, weAddr[0], ackCyc, 13 + D_PIPE);
      end
   endtask

   // 4-bit weight address wraps 15 -> 0 at beat 17 without disturbing completion
   task automatic test_wrap();
      captureLayer(5, 4, 1'b1, 1'b1, 0, 0);
      checks++;
      if (nBeats !== 20) begin
         errors++;
         $display("[TB] FAIL wrap_beats: got %0d expected 20", nBeats);
      end
      for (int b = 0; b < 20 && b < nBeats; b++) begin
         checks++;
         if (beatW[b] !== 16'(b % 16) || beatIn[b] !== 10'(b % 5)) begin
            errors++;
            $display("[TB] FAIL wrap_beat%0d: got w=%0d in=%0d expected w=%0d in=%0d", b, beatW[b], beatIn[b], b % 16, b % 5);
         end
      end
      checks++;
      if (nWe !== 4) begin
         errors++;
         $display("[TB] FAIL wrap_writes: got %0d expected 4", nWe);
      end
      for (int k = 0; k < 4 && k < nWe; k++) begin
         checks++;
         if (weCyc[k] !== (k + 1) * 5 + D_PIPE || weAddr[k] !== 10'(k)) begin
            errors++;
            $display("[TB] FAIL wrap_we%0d: got cyc=%0d addr=%0d expected cyc=%0d addr=%0d",
                     k, weCyc[k], weAddr[k], (k + 1) * 5 + D_PIPE, k);
         end
      end
      checks++;
      if (ackCyc !== 21 + D_PIPE || busyFall !== 22 + D_PIPE) begin
         errors++;
         $display("[TB] FAIL wrap_ack: got ack=%0d fall=%0d expected ack=%0d fall=%0d", ackCyc, busyFall, 21 + D_PIPE, 22 + D_PIPE);
      end
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_basic();
      test_empty();
      test_single();
      test_back_to_back();
      test_req_ignored();
      test_mid_reset();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
